// File: rtl/branch_pred_unit_pkg.sv
// Shared definitions for the branch prediction unit.
//   - Branch op codes (bra_beq .. bra_bgez); codes above BRA_OP_MAX are invalid.
//   - Two-bit saturating counter encodings for the pattern history table.
//   - pht_next(): one training step of a counter toward the actual outcome.
package branch_pred_unit_pkg;

  localparam logic [3:0] bra_beq    = 4'd0;
  localparam logic [3:0] bra_bne    = 4'd1;
  localparam logic [3:0] bra_blez   = 4'd2;
  localparam logic [3:0] bra_bgtz   = 4'd3;
  localparam logic [3:0] bra_bltz   = 4'd4;
  localparam logic [3:0] bra_bgez   = 4'd5;
  localparam logic [3:0] BRA_OP_MAX = 4'd5;

  localparam logic [1:0] PHT_SNT   = 2'b00;  // strong not-taken
  localparam logic [1:0] PHT_WNT   = 2'b01;  // weak not-taken
  localparam logic [1:0] PHT_WT    = 2'b10;  // weak taken
  localparam logic [1:0] PHT_ST    = 2'b11;  // strong taken
  localparam logic [1:0] PHT_RESET = PHT_WNT;

  // Move a counter one step toward the resolved direction, saturating at both ends.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == PHT_ST) ? PHT_ST : cnt + 2'd1;
    end
    return (cnt == PHT_SNT) ? PHT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_pred_unit_if.sv
// Pipeline-side bundle of the branch prediction unit.
//   F-stage : query_pc -> pred_taken (combinational prediction)
//   D-stage : resolve_valid, resolve_pc, resolve_pred, branchop, rs, rt
//             -> is_branch (combinational), mispredict (registered pulse)
//   Stats   : branch_count, mispredict_count
// Handshake: resolve_valid is a pure qualifier with no ready; the unit accepts a
// resolution on every rising clk edge where resolve_valid is high and the op is
// valid. The pipeline holds it low during stalls and flushes.
// master = pipeline controller side, slave = branch_pred_unit.
interface branch_pred_unit_if #(
  parameter int WIDTH  = 32,
  parameter int STAT_W = 32
);
  logic [31:0]       query_pc;
  logic              pred_taken;
  logic              resolve_valid;
  logic [31:0]       resolve_pc;
  logic              resolve_pred;
  logic [3:0]        branchop;
  logic [WIDTH-1:0]  rs;
  logic [WIDTH-1:0]  rt;
  logic              is_branch;
  logic              mispredict;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispredict_count;

  modport master (
    output query_pc, resolve_valid, resolve_pc, resolve_pred, branchop, rs, rt,
    input  pred_taken, is_branch, mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  query_pc, resolve_valid, resolve_pc, resolve_pred, branchop, rs, rt,
    output pred_taken, is_branch, mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_cmp.sv
// Combinational conditional-branch comparator.
//   branchop  : op code (see branch_pred_unit_pkg); invalid codes give 0
//   rs, rt    : forwarded operands, WIDTH bits; rt only matters for beq/bne
//   is_branch : 1 when the branch is taken
module branch_cmp
  import branch_pred_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       branchop,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             is_branch
);

  logic ops_equal;
  logic rs_zero;
  logic rs_neg;

  assign ops_equal = (rs == rt);
  assign rs_zero   = ~|rs;
  assign rs_neg    = rs[WIDTH-1];  // sign bit of rs as a signed value

  always_comb begin
    is_branch = 1'b0;
    case (branchop)
      bra_beq:  is_branch = ops_equal;
      bra_bne:  is_branch = ~ops_equal;
      bra_blez: is_branch = rs_neg | rs_zero;
      bra_bgtz: is_branch = ~rs_neg & ~rs_zero;
      bra_bltz: is_branch = rs_neg;
      bra_bgez: is_branch = ~rs_neg;
      default:  is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch prediction unit: D-stage branch resolution, a PC-indexed pattern
// history table of 2-bit saturating counters, a registered mispredict pulse
// and saturating branch/mispredict statistics.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : branch_pred_unit_if slave (query, resolution, results, stats)
// Parameters: WIDTH operand width, PHT_DEPTH table entries (power of two, >= 2),
// PRED_EN enables the table, STAT_W statistics counter width.
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 64,
  parameter int PRED_EN   = 1,
  parameter int STAT_W    = 32
) (
  input logic             clk,
  input logic             reset,
  branch_pred_unit_if.slave bus
);

  localparam int IDX_W = $clog2(PHT_DEPTH);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              is_branch_w;
  logic              res_ok;
  logic              mismatch;
  logic              mispredict_q;
  logic [STAT_W-1:0] branch_count_q;
  logic [STAT_W-1:0] mispredict_count_q;

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .branchop  (bus.branchop),
    .rs        (bus.rs),
    .rt        (bus.rt),
    .is_branch (is_branch_w)
  );

  assign bus.is_branch = is_branch_w;

  // A resolution only counts for a real branch in D with a legal op code.
  assign res_ok   = bus.resolve_valid & (bus.branchop <= BRA_OP_MAX);
  assign mismatch = is_branch_w ^ bus.resolve_pred;

  generate
    if (PRED_EN != 0) begin : g_pht
      logic [1:0]       pht [PHT_DEPTH];
      logic [IDX_W-1:0] q_idx;
      logic [IDX_W-1:0] r_idx;

      // Word-aligned PCs: bits [1:0] never select an entry.
      assign q_idx = bus.query_pc[IDX_W+1:2];
      assign r_idx = bus.resolve_pc[IDX_W+1:2];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PHT_DEPTH; i++) begin
            pht[i] <= PHT_RESET;
          end
        end else if (res_ok) begin
          pht[r_idx] <= pht_next(pht[r_idx], is_branch_w);
        end
      end

      // Plain array read, no bypass: a same-cycle update to the queried entry
      // shows up on the following cycle.
      assign bus.pred_taken = pht[q_idx][1];

      wire unused_pc_bits = ^{bus.query_pc[31:IDX_W+2], bus.query_pc[1:0],
                              bus.resolve_pc[31:IDX_W+2], bus.resolve_pc[1:0]};
    end else begin : g_no_pht
      assign bus.pred_taken = 1'b0;

      wire unused_pc_bits = ^{bus.query_pc, bus.resolve_pc};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      mispredict_q <= res_ok & mismatch;
      if (res_ok && (branch_count_q != STAT_MAX)) begin
        branch_count_q <= branch_count_q + STAT_ONE;
      end
      if (res_ok && mismatch && (mispredict_count_q != STAT_MAX)) begin
        mispredict_count_q <= mispredict_count_q + STAT_ONE;
      end
    end
  end

  assign bus.mispredict       = mispredict_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit. Three instances share one stimulus:
//   dut_a : default parameters
//   dut_b : PRED_EN = 0
//   dut_c : STAT_W = 4 (saturation)
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// after a change, registered outputs on the falling edge after the update.
module tb_branch_pred_unit;
  import branch_pred_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [31:0] query_pc;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_pred;
  logic [3:0]  branchop;
  logic [31:0] rs;
  logic [31:0] rt;

  int tests_run    = 0;
  int tests_failed = 0;

  branch_pred_unit_if #(.WIDTH(32), .STAT_W(32)) if_a ();
  branch_pred_unit_if #(.WIDTH(32), .STAT_W(32)) if_b ();
  branch_pred_unit_if #(.WIDTH(32), .STAT_W(4))  if_c ();

  assign if_a.query_pc = query_pc;  assign if_a.resolve_valid = resolve_valid;
  assign if_a.resolve_pc = resolve_pc;  assign if_a.resolve_pred = resolve_pred;
  assign if_a.branchop = branchop;  assign if_a.rs = rs;  assign if_a.rt = rt;

  assign if_b.query_pc = query_pc;  assign if_b.resolve_valid = resolve_valid;
  assign if_b.resolve_pc = resolve_pc;  assign if_b.resolve_pred = resolve_pred;
  assign if_b.branchop = branchop;  assign if_b.rs = rs;  assign if_b.rt = rt;

  assign if_c.query_pc = query_pc;  assign if_c.resolve_valid = resolve_valid;
  assign if_c.resolve_pc = resolve_pc;  assign if_c.resolve_pred = resolve_pred;
  assign if_c.branchop = branchop;  assign if_c.rs = rs;  assign if_c.rt = rt;

  branch_pred_unit #(.WIDTH(32), .PHT_DEPTH(64), .PRED_EN(1), .STAT_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  branch_pred_unit #(.WIDTH(32), .PHT_DEPTH(64), .PRED_EN(0), .STAT_W(32)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );
  branch_pred_unit #(.WIDTH(32), .PHT_DEPTH(64), .PRED_EN(1), .STAT_W(4)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic [31:0] qpc, input logic v, input logic [31:0] rpc,
                        input logic p, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    query_pc      = qpc;
    resolve_valid = v;
    resolve_pc    = rpc;
    resolve_pred  = p;
    branchop      = op;
    rs            = a;
    rt            = b;
  endtask

  // Compare sweep: op, rs, rt, expected is_branch.
  logic [3:0]  sw_op  [10] = '{bra_beq, bra_bne, bra_beq, bra_bgtz, bra_bgtz,
                               bra_bgez, bra_blez, bra_bltz, bra_bltz, bra_bgez};
  logic [31:0] sw_rs  [10] = '{32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'd1,
                               32'd0, 32'd0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
  logic [31:0] sw_rt  [10] = '{32'd5, 32'd5, 32'd6, 32'd0, 32'hFFFF_FFFF,
                               32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
  logic        sw_exp [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    // ---- reset state ----
    reset = 1'b1;
    set_in(32'h3000, 1'b0, 32'h0, 1'b0, bra_beq, 32'd0, 32'd0);
    #2;
    check("rst_pred_a", {63'd0, if_a.pred_taken}, 64'd0);
    check("rst_mispredict", {63'd0, if_a.mispredict}, 64'd0);
    check("rst_bcount", {32'd0, if_a.branch_count}, 64'd0);
    check("rst_mcount", {32'd0, if_a.mispredict_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("q3000_pred_a", {63'd0, if_a.pred_taken}, 64'd0);
    check("q3000_pred_b", {63'd0, if_b.pred_taken}, 64'd0);

    // ---- compare sweep, no resolution ----
    for (int i = 0; i < 10; i++) begin
      set_in(32'h3000, 1'b0, 32'h3000, 1'b0, sw_op[i], sw_rs[i], sw_rt[i]);
      #1;
      check($sformatf("cmp_%0d", i), {63'd0, if_a.is_branch}, {63'd0, sw_exp[i]});
    end

    // ---- invalid op with resolve_valid: no effect ----
    @(negedge clk);
    set_in(32'h3000, 1'b1, 32'h3000, 1'b1, 4'd7, 32'd5, 32'd5);
    #1;
    check("inv_is_branch", {63'd0, if_a.is_branch}, 64'd0);
    @(negedge clk);
    check("inv_bcount", {32'd0, if_a.branch_count}, 64'd0);
    check("inv_mispredict", {63'd0, if_a.mispredict}, 64'd0);
    check("inv_pred", {63'd0, if_a.pred_taken}, 64'd0);

    // ---- training at 0x3004: three taken beq ----
    // resolve_pred carries the prediction made at fetch: 0, then 1, 1.
    for (int i = 0; i < 3; i++) begin
      set_in(32'h3004, 1'b1, 32'h3004, (i != 0), bra_beq, 32'd5, 32'd5);
      #1;
      check($sformatf("train_pre_pred_%0d", i), {63'd0, if_a.pred_taken},
            {63'd0, (i != 0)});
      @(negedge clk);
      check($sformatf("train_mispredict_%0d", i), {63'd0, if_a.mispredict},
            {63'd0, (i == 0)});
      check($sformatf("train_post_pred_%0d", i), {63'd0, if_a.pred_taken}, 64'd1);
    end
    set_in(32'h3104, 1'b0, 32'h3104, 1'b0, bra_beq, 32'd5, 32'd5);
    #1;
    check("alias_pred_a", {63'd0, if_a.pred_taken}, 64'd1);
    check("alias_pred_b", {63'd0, if_b.pred_taken}, 64'd0);
    check("train_bcount", {32'd0, if_a.branch_count}, 64'd3);
    check("train_mcount", {32'd0, if_a.mispredict_count}, 64'd1);

    // ---- two not-taken: 11 -> 10 (still taken) -> 01 ----
    @(negedge clk);
    set_in(32'h3004, 1'b1, 32'h3004, 1'b1, bra_bne, 32'd5, 32'd5);
    @(negedge clk);
    check("nt1_pred", {63'd0, if_a.pred_taken}, 64'd1);
    check("nt1_mispredict", {63'd0, if_a.mispredict}, 64'd1);
    @(negedge clk);
    check("nt2_pred", {63'd0, if_a.pred_taken}, 64'd0);
    check("nt_bcount", {32'd0, if_a.branch_count}, 64'd5);
    check("nt_mcount", {32'd0, if_a.mispredict_count}, 64'd3);

    // ---- same-cycle collision at 0x3008 ----
    set_in(32'h3008, 1'b1, 32'h3008, 1'b0, bra_beq, 32'd7, 32'd7);
    #1;
    check("coll_pred_same", {63'd0, if_a.pred_taken}, 64'd0);
    @(negedge clk);
    check("coll_mispredict", {63'd0, if_a.mispredict}, 64'd1);
    set_in(32'h3008, 1'b0, 32'h3008, 1'b0, bra_beq, 32'd7, 32'd7);
    #1;
    check("coll_pred_next", {63'd0, if_a.pred_taken}, 64'd1);
    check("coll_pred_b", {63'd0, if_b.pred_taken}, 64'd0);

    // ---- stall: taken beq with resolve_valid low ----
    set_in(32'h300C, 1'b0, 32'h300C, 1'b0, bra_beq, 32'd9, 32'd9);
    #1;
    check("stall_is_branch", {63'd0, if_a.is_branch}, 64'd1);
    @(negedge clk);
    check("stall_pred", {63'd0, if_a.pred_taken}, 64'd0);
    check("stall_mispredict", {63'd0, if_a.mispredict}, 64'd0);
    check("stall_bcount", {32'd0, if_a.branch_count}, 64'd6);
    check("stall_mcount", {32'd0, if_a.mispredict_count}, 64'd4);
    check("nopred_bcount", {32'd0, if_b.branch_count}, 64'd6);
    check("nopred_mcount", {32'd0, if_b.mispredict_count}, 64'd4);

    // ---- saturation with STAT_W=4 ----
    reset = 1'b1;
    #1;
    reset = 1'b0;
    check("sat_start_bcount", {60'd0, if_c.branch_count}, 64'd0);
    for (int i = 0; i < 17; i++) begin
      set_in(32'h3020, 1'b1, 32'h3020, 1'b1, bra_bne, 32'd1, 32'd1);
      @(negedge clk);
      if (i == 13) begin
        check("sat14_bcount", {60'd0, if_c.branch_count}, 64'hE);
        check("sat14_mcount", {60'd0, if_c.mispredict_count}, 64'hE);
      end
    end
    check("sat_bcount", {60'd0, if_c.branch_count}, 64'hF);
    check("sat_mcount", {60'd0, if_c.mispredict_count}, 64'hF);
    check("sat_wide_bcount", {32'd0, if_a.branch_count}, 64'd17);

    // ---- asynchronous reset in mid-cycle ----
    set_in(32'h3010, 1'b1, 32'h3010, 1'b0, bra_beq, 32'd2, 32'd2);
    @(negedge clk);
    check("pre_rst_pred", {63'd0, if_a.pred_taken}, 64'd1);
    check("pre_rst_mispredict", {63'd0, if_c.mispredict}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pred", {63'd0, if_a.pred_taken}, 64'd0);
    check("arst_mispredict", {63'd0, if_c.mispredict}, 64'd0);
    check("arst_bcount_c", {60'd0, if_c.branch_count}, 64'd0);
    check("arst_mcount_c", {60'd0, if_c.mispredict_count}, 64'd0);
    check("arst_bcount_a", {32'd0, if_a.branch_count}, 64'd0);
    // A resolution held across an edge while reset is high is discarded.
    @(negedge clk);
    check("rst_hold_bcount", {32'd0, if_a.branch_count}, 64'd0);
    check("rst_hold_pred", {63'd0, if_a.pred_taken}, 64'd0);
    reset = 1'b0;
    set_in(32'h3010, 1'b0, 32'h3010, 1'b0, bra_beq, 32'd2, 32'd2);
    @(negedge clk);
    check("post_rst_bcount", {32'd0, if_a.branch_count}, 64'd0);
    check("post_rst_pred", {63'd0, if_a.pred_taken}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
